// File: rtl/warp_pkg.sv
// Shared types and width helpers for the warp engine memory adapter.
// Entry layout is common to the ROB and the adapter glue.
package warp_pkg;

    localparam int WARP_DATA_W = 32;

    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic                   is_write;
        logic [WARP_DATA_W-1:0] data;
    } rob_entry_t;

    function automatic int tag_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/warp_mem_rob.sv
// Reorder buffer: tag allocation at tail, out-of-order completion, in-order retire.
// A completion that hits the current head retires in the same cycle.
module warp_mem_rob
    import warp_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int TW    = tag_w(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_en,
    input  logic                   alloc_write,
    output logic [TW-1:0]          tail,
    input  logic                   cpl_en,
    input  logic [TW-1:0]          cpl_tag,
    input  logic [WARP_DATA_W-1:0] cpl_data,
    output logic                   cpl_ok,
    output logic                   ret_en,
    output logic                   ret_write,
    output logic [WARP_DATA_W-1:0] ret_data,
    output logic                   full,
    output logic                   empty
);

    rob_entry_t     r_rob [DEPTH];
    logic [TW-1:0]  r_head;
    logic [TW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    rob_entry_t     w_head;
    logic           w_bypass;

    assign w_head    = r_rob[r_head];
    assign cpl_ok    = cpl_en & r_rob[cpl_tag].valid & ~r_rob[cpl_tag].done;
    assign w_bypass  = cpl_ok & (cpl_tag == r_head);
    assign ret_en    = w_head.valid & (w_head.done | w_bypass);
    assign ret_write = w_head.is_write;
    assign ret_data  = w_head.done ? w_head.data : cpl_data;
    assign tail      = r_tail;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_rob[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (cpl_ok) begin
                r_rob[cpl_tag].done <= 1'b1;
                r_rob[cpl_tag].data <= cpl_data;
            end
            if (alloc_en) begin
                r_rob[r_tail] <= '{valid: 1'b1, done: 1'b0,
                                   is_write: alloc_write, data: '0};
                r_tail <= r_tail + 1'b1;
            end
            // Retire last so a same-cycle bypass completion is cleared.
            if (ret_en) begin
                r_rob[r_head].valid <= 1'b0;
                r_rob[r_head].done  <= 1'b0;
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(alloc_en) - CW'(ret_en);
        end
    end

endmodule

// File: rtl/warp_mem_adapter.sv
// In-order untagged engine port onto a tagged out-of-order bus via a ROB.
// Optional watchdog: define WARP_MEM_ADAPTER_TIMEOUT_EN to add err_timeout.
module warp_mem_adapter
    import warp_pkg::*;
#(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = WARP_DATA_W,
    parameter  int MAX_OUTSTANDING = 8,
    parameter  int TIMEOUT_CYCLES  = 1024,
    localparam int TAG_WIDTH       = tag_w(MAX_OUTSTANDING)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  eng_req_valid,
    output logic                  eng_req_ready,
    input  logic [ADDR_WIDTH-1:0] eng_req_addr,
    input  logic                  eng_req_write,
    input  logic [DATA_WIDTH-1:0] eng_req_data,
    output logic                  eng_resp_valid,
    output logic [DATA_WIDTH-1:0] eng_resp_data,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic [TAG_WIDTH-1:0]  bus_req_tag,
    output logic [ADDR_WIDTH-1:0] bus_req_addr,
    output logic                  bus_req_write,
    output logic [DATA_WIDTH-1:0] bus_req_data,
    input  logic                  bus_resp_valid,
    input  logic [TAG_WIDTH-1:0]  bus_resp_tag,
    input  logic [DATA_WIDTH-1:0] bus_resp_data,
    output logic                  err_spurious
`ifdef WARP_MEM_ADAPTER_TIMEOUT_EN
    ,
    output logic                  err_timeout
`endif
);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_fire;
    logic                  w_cpl_ok;
    logic                  w_ret_en;
    logic                  w_ret_write;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_err_spurious;

    assign bus_req_valid = eng_req_valid & ~w_full;
    assign eng_req_ready = bus_req_ready & ~w_full;
    assign w_fire        = eng_req_valid & eng_req_ready;
    assign bus_req_addr  = eng_req_addr;
    assign bus_req_write = eng_req_write;
    assign bus_req_data  = eng_req_data;

    warp_mem_rob #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rob (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (w_fire),
        .alloc_write (eng_req_write),
        .tail        (bus_req_tag),
        .cpl_en      (bus_resp_valid),
        .cpl_tag     (bus_resp_tag),
        .cpl_data    (bus_resp_data),
        .cpl_ok      (w_cpl_ok),
        .ret_en      (w_ret_en),
        .ret_write   (w_ret_write),
        .ret_data    (w_ret_data),
        .full        (w_full),
        .empty       (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid   <= 1'b0;
            r_resp_data    <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_resp_valid <= w_ret_en & ~w_ret_write;
            if (w_ret_en & ~w_ret_write) r_resp_data <= w_ret_data;
            if (bus_resp_valid & ~w_cpl_ok) r_err_spurious <= 1'b1;
        end
    end

    assign eng_resp_valid = r_resp_valid;
    assign eng_resp_data  = r_resp_data;
    assign err_spurious   = r_err_spurious;

`ifdef WARP_MEM_ADAPTER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOW-1:0] r_to_cnt;
    logic           r_err_timeout;

    // Counts cycles the head has waited; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_ret_en || w_empty) r_to_cnt <= '0;
            else if (r_to_cnt != TOW'(TIMEOUT_CYCLES)) r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TOW'(TIMEOUT_CYCLES) && !w_ret_en && !w_empty)
                r_err_timeout <= 1'b1;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    wire w_unused_empty = w_empty;
`endif

endmodule

// File: tb/tb_warp_mem_adapter.sv
// Scoreboard bench for warp_mem_adapter: expected load data queued at issue,
// monitor pops on every eng_resp_valid; directed timing checks inline.
module tb_warp_mem_adapter;

    logic        clk;
    logic        rst;
    logic        eng_req_valid;
    logic        eng_req_ready;
    logic [31:0] eng_req_addr;
    logic        eng_req_write;
    logic [31:0] eng_req_data;
    logic        eng_resp_valid;
    logic [31:0] eng_resp_data;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [2:0]  bus_req_tag;
    logic [31:0] bus_req_addr;
    logic        bus_req_write;
    logic [31:0] bus_req_data;
    logic        bus_resp_valid;
    logic [2:0]  bus_resp_tag;
    logic [31:0] bus_resp_data;
    logic        err_spurious;
`ifdef WARP_MEM_ADAPTER_TIMEOUT_EN
    logic        err_timeout;
`endif

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q [$];
    logic [2:0]  exp_tail = '0;

    int          t2_v   [6] = '{1, 1, 1, 0, 0, 0};
    int          t2_tag [6] = '{3, 1, 2, 0, 0, 0};
    int          t2_ev  [6] = '{0, 0, 1, 1, 1, 0};

    warp_mem_adapter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (8),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .eng_req_valid  (eng_req_valid),
        .eng_req_ready  (eng_req_ready),
        .eng_req_addr   (eng_req_addr),
        .eng_req_write  (eng_req_write),
        .eng_req_data   (eng_req_data),
        .eng_resp_valid (eng_resp_valid),
        .eng_resp_data  (eng_resp_data),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_tag    (bus_req_tag),
        .bus_req_addr   (bus_req_addr),
        .bus_req_write  (bus_req_write),
        .bus_req_data   (bus_req_data),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_tag   (bus_resp_tag),
        .bus_resp_data  (bus_resp_data),
        .err_spurious   (err_spurious)
`ifdef WARP_MEM_ADAPTER_TIMEOUT_EN
        ,
        .err_timeout    (err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Monitor: every engine response must match the oldest queued load.
    always @(negedge clk) begin
        if (eng_resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL resp_unexpected: got %08h expected none",
                         eng_resp_data);
            end else begin
                chk("resp_data", eng_resp_data, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic issue(input logic [31:0] addr, input logic wr,
                         input logic [31:0] d, input logic push);
        eng_req_valid = 1'b1;
        eng_req_addr  = addr;
        eng_req_write = wr;
        eng_req_data  = d;
        @(negedge clk);
        chk("req_ready", eng_req_ready, 1);
        chk("req_tag", bus_req_tag, exp_tail);
        chk("req_addr", bus_req_addr, addr);
        @(posedge clk); #1;
        eng_req_valid = 1'b0;
        exp_tail++;
        if (!wr && push) exp_q.push_back(d);
    endtask

    task automatic respond(input logic [2:0] tag, input logic [31:0] d);
        bus_resp_valid = 1'b1;
        bus_resp_tag   = tag;
        bus_resp_data  = d;
        @(posedge clk); #1;
        bus_resp_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        eng_req_valid  = 1'b0;
        eng_req_addr   = '0;
        eng_req_write  = 1'b0;
        eng_req_data   = '0;
        bus_req_ready  = 1'b1;
        bus_resp_valid = 1'b0;
        bus_resp_tag   = '0;
        bus_resp_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", eng_resp_valid, 0);
        chk("rst_resp_data", eng_resp_data, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_tag", bus_req_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // 1: single load, head response returns next cycle
        issue(32'h100, 1'b0, 32'hDEADBEEF, 1'b1);
        respond(3'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_valid", eng_resp_valid, 1);
        step();
        @(negedge clk);
        chk("t1_pulse", eng_resp_valid, 0);
        step();

        // 2: tags 1,2,3 answered 3,1,2 -> delivered 1,2,3 back to back
        for (int i = 1; i <= 3; i++)
            issue(32'h200 + 32'(i), 1'b0, 32'h11111111 * 32'(i), 1'b1);
        for (int i = 0; i < 6; i++) begin
            bus_resp_valid = t2_v[i][0];
            bus_resp_tag   = 3'(t2_tag[i]);
            bus_resp_data  = 32'h11111111 * 32'(t2_tag[i]);
            @(negedge clk);
            chk("t2_valid", eng_resp_valid, 32'(t2_ev[i]));
            step();
        end
        bus_resp_valid = 1'b0;

        // 3: fill all 8 slots, stall, free head, wrap onto freed tag
        for (int i = 0; i < 8; i++)
            issue(32'h300 + 32'(i), 1'b0, 32'hA000 + 32'(i), 1'b1);
        eng_req_valid = 1'b1;
        eng_req_addr  = 32'h308;
        eng_req_write = 1'b0;
        @(negedge clk);
        chk("t3_full_ready", eng_req_ready, 0);
        chk("t3_full_bvalid", bus_req_valid, 0);
        step();
        bus_resp_valid = 1'b1;
        bus_resp_tag   = 3'd4;
        bus_resp_data  = 32'hA000;
        @(negedge clk);
        chk("t3_still_full", eng_req_ready, 0);
        step();
        bus_resp_valid = 1'b0;
        @(negedge clk);
        chk("t3_freed_ready", eng_req_ready, 1);
        chk("t3_wrap_tag", bus_req_tag, 4);
        step();
        eng_req_valid = 1'b0;
        exp_tail++;
        exp_q.push_back(32'hA008);
        for (int i = 1; i < 8; i++)
            respond(3'(4 + i), 32'hA000 + 32'(i));
        respond(3'd4, 32'hA008);
        step();

        // 4: bus stall, then store ack is silent and load returns 0x5
        eng_req_valid = 1'b1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        chk("t4_stall_ready", eng_req_ready, 0);
        chk("t4_stall_bvalid", bus_req_valid, 1);
        step();
        eng_req_valid = 1'b0;
        bus_req_ready = 1'b1;
        issue(32'h400, 1'b1, 32'h77, 1'b1);
        issue(32'h404, 1'b0, 32'h5, 1'b1);
        respond(3'd5, 32'hFFFF);
        @(negedge clk);
        chk("t4_store_silent", eng_resp_valid, 0);
        step();
        respond(3'd6, 32'h5);
        @(negedge clk);
        chk("t4_load_valid", eng_resp_valid, 1);
        step();
        step();

        // 5: spurious response on empty ROB, then async reset
        respond(3'd3, 32'h99);
        @(negedge clk);
        chk("t5_spurious", err_spurious, 1);
        chk("t5_no_resp", eng_resp_valid, 0);
        chk("t5_ready", eng_req_ready, 1);
        chk("t5_tag", bus_req_tag, exp_tail);
        step();
        issue(32'h500, 1'b0, 32'h0, 1'b0);
        issue(32'h504, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", eng_resp_valid, 0);
        chk("t5_rst_data", eng_resp_data, 0);
        chk("t5_rst_err", err_spurious, 0);
        chk("t5_rst_tag", bus_req_tag, 0);
        exp_tail = '0;
        step();
        rst = 1'b0;
        step();

        // Response in the allocation cycle is spurious; real one retires
        eng_req_valid  = 1'b1;
        eng_req_addr   = 32'h600;
        eng_req_write  = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_tag   = 3'd0;
        bus_resp_data  = 32'hBAD;
        step();
        eng_req_valid  = 1'b0;
        bus_resp_valid = 1'b0;
        exp_tail++;
        @(negedge clk);
        chk("alloc_spurious", err_spurious, 1);
        chk("alloc_no_resp", eng_resp_valid, 0);
        step();
        exp_q.push_back(32'hCAFE);
        respond(3'd0, 32'hCAFE);
        @(negedge clk);
        chk("alloc_late_valid", eng_resp_valid, 1);
        step();

`ifdef WARP_MEM_ADAPTER_TIMEOUT_EN
        // 6: unanswered load trips the watchdog, late response still retires
        issue(32'h700, 1'b0, 32'h1234, 1'b1);
        repeat (10) step();
        @(negedge clk);
        chk("t6_no_timeout", err_timeout, 0);
        repeat (15) step();
        @(negedge clk);
        chk("t6_timeout", err_timeout, 1);
        step();
        respond(3'd1, 32'h1234);
        @(negedge clk);
        chk("t6_late_valid", eng_resp_valid, 1);
        chk("t6_sticky", err_timeout, 1);
        step();
`endif

        repeat (4) step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
